// File: rtl/system_nios2_qsys_div_cell_if.sv
// Request/response bundle between the Nios II A-stage and the iterative divider.
// The master side issues divide requests; the slave side is the divider cell.
interface system_nios2_qsys_div_cell_if #(
    parameter int unsigned DIV_WIDTH = 32
);
    logic                 A_div_start;
    logic                 A_div_signed;
    logic [DIV_WIDTH-1:0] A_div_src1;
    logic [DIV_WIDTH-1:0] A_div_src2;
    logic                 A_div_busy;
    logic                 A_div_done;
    logic [DIV_WIDTH-1:0] A_div_quotient;
    logic [DIV_WIDTH-1:0] A_div_remainder;

    modport master (
        output A_div_start,
        output A_div_signed,
        output A_div_src1,
        output A_div_src2,
        input  A_div_busy,
        input  A_div_done,
        input  A_div_quotient,
        input  A_div_remainder
    );

    modport slave (
        input  A_div_start,
        input  A_div_signed,
        input  A_div_src1,
        input  A_div_src2,
        output A_div_busy,
        output A_div_done,
        output A_div_quotient,
        output A_div_remainder
    );
endinterface

// File: rtl/system_nios2_qsys_div_cell.sv
// Fixed-latency radix-2 restoring divider (div/divu) for the Nios II execute stage.
// Signed operands are divided as magnitudes and the signs are reapplied in FIX.
module system_nios2_qsys_div_cell #(
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    system_nios2_qsys_div_cell_if.slave   div_if
);

    localparam int unsigned W     = DIV_WIDTH;
    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [W-1:0]       quo_q, quo_d;
    logic [W-1:0]       dvsr_q, dvsr_d;
    logic [W-1:0]       orig_q, orig_d;
    logic               signed_q, signed_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W-1:0]       quotient_q, quotient_d;
    logic [W-1:0]       remainder_q, remainder_d;

    // Partial remainder shifted left with the next dividend bit; needs W+1 bits
    // because the magnitude divisor may use the full W bits.
    logic [W:0]         rem_sh;
    logic [W:0]         trial;

    assign rem_sh = {rem_q, quo_q[W-1]};
    assign trial  = rem_sh - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            orig_q      <= '0;
            signed_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            orig_q      <= orig_d;
            signed_q    <= signed_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        orig_d      = orig_q;
        signed_d    = signed_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            S_IDLE: begin
                if (div_if.A_div_start) begin
                    quo_d    = div_if.A_div_src1;
                    orig_d   = div_if.A_div_src1;
                    dvsr_d   = div_if.A_div_src2;
                    signed_d = div_if.A_div_signed;
                    busy_d   = 1'b1;
                    state_d  = S_PREP;
                end
            end

            S_PREP: begin
                if (signed_q && quo_q[W-1]) begin
                    quo_d = ~quo_q + W'(1);
                end
                if (signed_q && dvsr_q[W-1]) begin
                    dvsr_d = ~dvsr_q + W'(1);
                end
                q_neg_d = signed_q & (quo_q[W-1] ^ dvsr_q[W-1]);
                r_neg_d = signed_q & quo_q[W-1];
                dbz_d   = (dvsr_q == '0);
                rem_d   = '0;
                cnt_d   = CNT_W'(W - 1);
                state_d = S_ITER;
            end

            S_ITER: begin
                // Restore on a negative trial, otherwise keep the difference.
                if (!trial[W]) begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = orig_q;
                end else begin
                    quotient_d  = q_neg_q ? (~quo_q + W'(1)) : quo_q;
                    remainder_d = r_neg_q ? (~rem_q + W'(1)) : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_if.A_div_busy      = busy_q;
    assign div_if.A_div_done      = done_q;
    assign div_if.A_div_quotient  = quotient_q;
    assign div_if.A_div_remainder = remainder_q;

endmodule

// File: tb/tb_system_nios2_qsys_div_cell.sv
// Directed and random checks of the divider: latency, busy window, signed/unsigned
// results, divide-by-zero, dropped starts while busy, and mid-operation reset.
module tb_system_nios2_qsys_div_cell;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    system_nios2_qsys_div_cell_if #(.DIV_WIDTH(32)) dif ();

    system_nios2_qsys_div_cell #(.DIV_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: truncating division, remainder follows dividend, x/0 -> {all ones, x}.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sb_v;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            sa   = a;
            sb_v = b;
            e.q  = 32'(sa / sb_v);
            e.r  = 32'(sa % sb_v);
        end
        return e;
    endfunction

    // Issue one divide (sampled at the next edge, "cycle 0") and observe cycles 1..36.
    // Optional junk starts with other operands are pulsed in cycles j1/j2.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e, input int j1, input int j2);
        int   busy_bad = 0;
        int   done_cnt = 0;
        int   done_cyc = -1;
        exp_t got;
        sb.push_back(e);
        dif.A_div_start  = 1'b1;
        dif.A_div_signed = s;
        dif.A_div_src1   = a;
        dif.A_div_src2   = b;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (cyc == j1 || cyc == j2) begin
                dif.A_div_start  = 1'b1;
                dif.A_div_signed = 1'b0;
                dif.A_div_src1   = 32'd9;
                dif.A_div_src2   = 32'd3;
            end else begin
                dif.A_div_start  = 1'b0;
            end
            if (dif.A_div_busy !== (cyc <= 35)) busy_bad++;
            if (dif.A_div_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk({tag, "_quotient"}, dif.A_div_quotient, got.q);
                    chk({tag, "_remainder"}, dif.A_div_remainder, got.r);
                end
            end
        end
        chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd35);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_hold_quotient"}, dif.A_div_quotient, e.q);
    endtask

    initial begin
        int          stray_done;
        int          stray_busy;
        logic [31:0] ra, rb;
        logic        rs;

        reset            = 1'b1;
        dif.A_div_start  = 1'b0;
        dif.A_div_signed = 1'b0;
        dif.A_div_src1   = '0;
        dif.A_div_src2   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(dif.A_div_busy), 32'd0);
        chk("reset_done", 32'(dif.A_div_done), 32'd0);
        chk("reset_quotient", dif.A_div_quotient, 32'd0);
        chk("reset_remainder", dif.A_div_remainder, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, '{q: 32'd14, r: 32'd2}, 0, 0);
        run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
               '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF}, 0, 0);
        run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               '{q: 32'h8000_0000, r: 32'd0}, 0, 0);
        run_op("udiv_by0", 1'b0, 32'h1234_5678, 32'd0,
               '{q: 32'hFFFF_FFFF, r: 32'h1234_5678}, 0, 0);
        run_op("sdiv_by0", 1'b1, 32'h1234_5678, 32'd0,
               '{q: 32'hFFFF_FFFF, r: 32'h1234_5678}, 0, 0);
        run_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
               '{q: 32'hFFFF_FFFF, r: 32'd0}, 0, 0);
        run_op("udiv_5_max", 1'b0, 32'd5, 32'hFFFF_FFFF, '{q: 32'd0, r: 32'd5}, 0, 0);

        // Starts in cycles 10 and 35 are dropped; the one in cycle 36 is accepted.
        run_op("busy_drop", 1'b0, 32'd100, 32'd7, '{q: 32'd14, r: 32'd2}, 10, 35);
        run_op("b2b_9_3", 1'b0, 32'd9, 32'd3, '{q: 32'd3, r: 32'd0}, 0, 0);

        // Reset in cycle 20 of an operation, with a start in the same cycle.
        dif.A_div_start  = 1'b1;
        dif.A_div_signed = 1'b0;
        dif.A_div_src1   = 32'd1000;
        dif.A_div_src2   = 32'd3;
        @(posedge clk);
        #1;
        dif.A_div_start = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        reset           = 1'b1;
        dif.A_div_start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'(dif.A_div_busy), 32'd0);
        chk("rst_mid_done", 32'(dif.A_div_done), 32'd0);
        chk("rst_mid_quotient", dif.A_div_quotient, 32'd0);
        chk("rst_mid_remainder", dif.A_div_remainder, 32'd0);
        reset           = 1'b0;
        dif.A_div_start = 1'b0;
        stray_done = 0;
        stray_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (dif.A_div_done === 1'b1) stray_done++;
            if (dif.A_div_busy === 1'b1) stray_busy++;
        end
        chk("rst_no_done", 32'(stray_done), 32'd0);
        chk("rst_no_busy", 32'(stray_busy), 32'd0);

        run_op("after_rst", 1'b0, 32'd1000, 32'd3, '{q: 32'd333, r: 32'd1}, 0, 0);

        for (int k = 0; k < 6; k++) begin
            rs = k[0];
            ra = $urandom;
            rb = (k == 2) ? 32'($urandom_range(1, 255)) : $urandom;
            if (k == 4) rb = rb >> 20;
            run_op($sformatf("rand%0d", k), rs, ra, rb, model(rs, ra, rb), 0, 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/system_nios2_qsys_div_cell.md
# system_nios2_qsys_div_cell

Iterative 32-bit integer divider for the Nios II execute stage, the inverse counterpart of the pipelined multiplier cell. It accepts a dividend/divisor pair with a one-cycle start strobe and computes quotient and remainder with a radix-2 restoring algorithm. After a fixed latency it returns both results with a one-cycle done pulse. It serves `div`/`divu` and software remainder sequences, and stalls the A-stage while busy.

## Interface
- `DIV_WIDTH`, 32, operand/result width; latency scales as DIV_WIDTH+3.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A_div_start`  in  1  request strobe; accepted only when `A_div_busy`=0.
- `A_div_signed`  in  1  1 = two's-complement (`div`), 0 = unsigned (`divu`); captured with start.
- `A_div_src1`  in  DIV_WIDTH  dividend; captured with start.
- `A_div_src2`  in  DIV_WIDTH  divisor; captured with start.
- `A_div_busy`  out  1  high from the cycle after an accepted start up to and including the done cycle.
- `A_div_done`  out  1  one-cycle pulse; results are valid in this cycle.
- `A_div_quotient`  out  DIV_WIDTH  registered quotient; held until the next accepted start.
- `A_div_remainder`  out  DIV_WIDTH  registered remainder; held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: `A_div_start`=1 captures the operands and the signed flag, then moves to PREP. All other inputs are ignored.
- PREP (1 cycle): in signed mode, takes magnitudes of both operands. Records `q_neg` = sign1 XOR sign2 and `r_neg` = sign1. Flags divide-by-zero. Clears the partial remainder. Loads the iteration counter with DIV_WIDTH-1.
- ITER (DIV_WIDTH cycles), each cycle:
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - trial subtraction uses DIV_WIDTH+1 bits;
  - if the result is non-negative, rem takes the difference and the quo LSB becomes 1;
  - the counter decrements; when the counter reaches 0, move to FIX.
- FIX (1 cycle):
  - negates quo if `q_neg` and negates rem if `r_neg` (signed mode only), then registers both outputs.
  - Divide-by-zero overrides the result: quotient = all ones, remainder = original dividend (unsigned and signed alike).
- DONE (1 cycle): `A_div_done`=1, then return to IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out naturally from magnitude arithmetic; no special case is needed.
- Rounding: quotient truncates toward zero; the remainder sign follows the dividend.
- A start asserted while busy (including the DONE cycle) is dropped with no side effect.
- Operands may change freely after capture.

## Timing
- Reset values: `A_div_busy`=0, `A_div_done`=0, `A_div_quotient`=0, `A_div_remainder`=0, state=IDLE.
- Call the edge that samples the start cycle 0.
  - Cycle 1: PREP, `A_div_busy`=1.
  - Cycles 2..33: ITER.
  - Cycle 34: FIX.
  - Cycle 35: `A_div_done`=1 with valid outputs.
- Latency is a fixed DIV_WIDTH+3 = 35 cycles from start to done, including divide-by-zero and overflow cases. There is no early termination.
- Back-to-back: a new start is accepted in the first IDLE cycle, which is cycle 36. Maximum throughput is one division per 36 cycles.
- Outputs update only at the FIX→DONE edge and are stable from then until the next FIX.
- Reset asserted in any state:
  - next state is IDLE, with busy, done and both outputs cleared;
  - the in-flight operation is discarded and no done pulse is generated;
  - a start in the same cycle as reset is ignored.

## Test plan
- Unsigned divide: start with src1=100, src2=7, signed=0. Require quotient=14 and remainder=2, with done exactly 35 cycles after the start edge and busy high for cycles 1..35.
- Signed negative dividend: src1=0xFFFFFFF9 (-7), src2=2, signed=1. Require quotient=0xFFFFFFFD (-3) and remainder=0xFFFFFFFF (-1).
  - Also run src1=0x80000000, src2=0xFFFFFFFF, signed=1. Require quotient=0x80000000 and remainder=0.
- Divide by zero: src1=0x12345678, src2=0, run in both modes. Require quotient=0xFFFFFFFF, remainder=0x12345678, and done still at cycle 35.
- Unsigned boundary: src1=0xFFFFFFFF, src2=1, signed=0. Require quotient=0xFFFFFFFF and remainder=0.
  - Also run src1=5, src2=0xFFFFFFFF, signed=0. Require quotient=0 and remainder=5.
- Busy protection: start a divide 100/7, then pulse start at cycles 10 and 35 with 9/3 and change the src inputs. Require a single done at cycle 35 with 14/2 only.
  - A start at cycle 36 is accepted and produces 3/0 at cycle 71.
- Reset mid-operation: assert reset at cycle 20 of a divide. Require busy=0, done=0 and outputs=0 on the next cycle, and no done pulse afterwards.
  - A new start after reset deassertion completes normally in 35 cycles.
